// File: rtl/pa_idu_wb_arb.sv
// ----------------------------------------------------------------------------
// pa_idu_wb_arb
//
// Purpose:
//   Arbitrates the single GPR write-back port among three producers:
//     - ALU pipeline  (cannot stall, single-cycle valid, always wins)
//     - LSU load data (held valid until lsu_wb_rdy)
//     - Divider       (held valid until div_wb_rdy)
//   LSU and DIV share a round-robin slot. A saturating starvation counter
//   tracks how long a pending LSU/DIV request keeps losing to the ALU. Once
//   it saturates, arb_alu_stall_req asks issue to hold off ALU instructions.
//   The winner is registered into a one-cycle-latency write-back stage that
//   also produces the one-hot per-register write enable for the scoreboard.
//
// Ports:
//   cpuclk, cpurst          core clock, asynchronous active-high reset
//   alu_wb_vld/dst/data     ALU write-back request (no ready; always granted)
//   lsu_wb_vld/dst/data     LSU load write-back request
//   lsu_wb_rdy              LSU granted this cycle (combinational)
//   div_wb_vld/dst/data     divider write-back request
//   div_wb_rdy              DIV granted this cycle (combinational)
//   arb_alu_stall_req       registered request to block ALU issue
//   wb_vld/dst/data         registered write-back bus
//   wb_flsu_vld             registered: current write-back came from the LSU
//   wb_reg_write_en         registered one-hot GPR write enable (bit 0 never set)
// ----------------------------------------------------------------------------
module pa_idu_wb_arb #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic        cpuclk,
    input  logic        cpurst,

    input  logic        alu_wb_vld,
    input  logic [4:0]  alu_wb_dst,
    input  logic [31:0] alu_wb_data,

    input  logic        lsu_wb_vld,
    input  logic [4:0]  lsu_wb_dst,
    input  logic [31:0] lsu_wb_data,
    output logic        lsu_wb_rdy,

    input  logic        div_wb_vld,
    input  logic [4:0]  div_wb_dst,
    input  logic [31:0] div_wb_data,
    output logic        div_wb_rdy,

    output logic        arb_alu_stall_req,

    output logic        wb_vld,
    output logic [4:0]  wb_dst,
    output logic [31:0] wb_data,
    output logic        wb_flsu_vld,
    output logic [31:0] wb_reg_write_en
);

    localparam logic [CNT_W-1:0] LP_STARVE_MAX = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] LP_CNT_ONE    = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // r_rr_last: 0 = LSU won the last contended round, 1 = DIV won it.
    logic             r_rr_last;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_stall;
    logic             r_wb_vld;
    logic [4:0]       r_wb_dst;
    logic [31:0]      r_wb_data;
    logic             r_wb_flsu;
    logic [31:0]      r_wb_wen;

    // ------------------------------------------------------------------
    // Combinational grant and next-state
    // ------------------------------------------------------------------
    logic             w_gnt_alu;
    logic             w_gnt_lsu;
    logic             w_gnt_div;
    logic             w_gnt_any;
    logic             w_gnt_side;
    logic             w_side_req;
    logic             w_contend;
    logic [4:0]       w_sel_dst;
    logic [31:0]      w_sel_data;
    logic [31:0]      w_sel_wen;
    logic             w_rr_last_d;
    logic [CNT_W-1:0] w_starve_cnt_d;
    logic             w_stall_d;

    always_comb begin
        // Grants are suppressed while reset is held so no handshake can
        // complete that the (cleared) write-back stage would not record.
        w_side_req = lsu_wb_vld | div_wb_vld;
        w_contend  = ~cpurst & ~alu_wb_vld & lsu_wb_vld & div_wb_vld;
        w_gnt_alu  = ~cpurst & alu_wb_vld;
        w_gnt_lsu  = ~cpurst & ~alu_wb_vld & lsu_wb_vld & (~div_wb_vld | r_rr_last);
        w_gnt_div  = ~cpurst & ~alu_wb_vld & div_wb_vld & (~lsu_wb_vld | ~r_rr_last);
        w_gnt_side = w_gnt_lsu | w_gnt_div;
        w_gnt_any  = w_gnt_alu | w_gnt_side;
    end

    always_comb begin
        w_sel_dst  = 5'd0;
        w_sel_data = 32'd0;
        if (w_gnt_alu) begin
            w_sel_dst  = alu_wb_dst;
            w_sel_data = alu_wb_data;
        end else if (w_gnt_lsu) begin
            w_sel_dst  = lsu_wb_dst;
            w_sel_data = lsu_wb_data;
        end else if (w_gnt_div) begin
            w_sel_dst  = div_wb_dst;
            w_sel_data = div_wb_data;
        end
        // x0 is hardwired: a write to it still signals wb_vld but enables nothing.
        w_sel_wen = (w_sel_dst == 5'd0) ? 32'd0 : (32'd1 << w_sel_dst);
    end

    always_comb begin
        // Round-robin pointer moves only when both side requesters competed.
        w_rr_last_d = r_rr_last;
        if (w_contend) begin
            w_rr_last_d = w_gnt_div;
        end

        // Counter counts cycles a side request loses; any side grant or an
        // idle side path restarts it.
        w_starve_cnt_d = '0;
        if (w_side_req && !w_gnt_side) begin
            w_starve_cnt_d = (r_starve_cnt == LP_STARVE_MAX) ? r_starve_cnt
                                                             : r_starve_cnt + LP_CNT_ONE;
        end

        // Stall keys off the registered count, so a grant in the cycle the
        // count would saturate never raises the stall.
        w_stall_d = r_stall;
        if (w_gnt_side || !w_side_req) begin
            w_stall_d = 1'b0;
        end else if (r_starve_cnt == LP_STARVE_MAX) begin
            w_stall_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration state
    // ------------------------------------------------------------------
    always_ff @(posedge cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_rr_last    <= 1'b0;
            r_starve_cnt <= '0;
            r_stall      <= 1'b0;
        end else begin
            r_rr_last    <= w_rr_last_d;
            r_starve_cnt <= w_starve_cnt_d;
            r_stall      <= w_stall_d;
        end
    end

    // ------------------------------------------------------------------
    // Write-back stage: dst/data hold when nothing is granted so the bus
    // only toggles on real write-backs.
    // ------------------------------------------------------------------
    always_ff @(posedge cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_wb_vld  <= 1'b0;
            r_wb_dst  <= 5'd0;
            r_wb_data <= 32'd0;
            r_wb_flsu <= 1'b0;
            r_wb_wen  <= 32'd0;
        end else begin
            r_wb_vld  <= w_gnt_any;
            r_wb_flsu <= w_gnt_lsu;
            r_wb_wen  <= w_gnt_any ? w_sel_wen : 32'd0;
            if (w_gnt_any) begin
                r_wb_dst  <= w_sel_dst;
                r_wb_data <= w_sel_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign lsu_wb_rdy        = w_gnt_lsu;
    assign div_wb_rdy        = w_gnt_div;
    assign arb_alu_stall_req = r_stall;
    assign wb_vld            = r_wb_vld;
    assign wb_dst            = r_wb_dst;
    assign wb_data           = r_wb_data;
    assign wb_flsu_vld       = r_wb_flsu;
    assign wb_reg_write_en   = r_wb_wen;

endmodule

// File: doc/pa_idu_wb_arb.md
Name: pa_idu_wb_arb

Overview:
- Arbitrates the single GPR write-back port among three producers: the ALU pipeline, which cannot stall; LSU load return; and the divider.
- Drives the registered write-back bus and the per-register write-enable vector consumed by the GPR scoreboard entries. The scoreboard entries use reg_write_en_x and the LSU-source flag to retire their busy state.
- Provides round-robin fairness between LSU and DIV, plus starvation relief that requests an ALU issue stall.

Parameters:
STARVE_MAX, 4, number of consecutive cycles a pending LSU/DIV request may lose before arb_alu_stall_req asserts (range 1..2^CNT_W-1)
CNT_W, 3, width of the starvation counter

Ports:
cpuclk  input  1  core clock
cpurst  input  1  asynchronous, active-high reset
alu_wb_vld  input  1  ALU write-back valid (single cycle, never held)
alu_wb_dst  input  5  ALU destination GPR index
alu_wb_data  input  32  ALU result
lsu_wb_vld  input  1  LSU load write-back valid (held until lsu_wb_rdy)
lsu_wb_dst  input  5  LSU destination GPR index
lsu_wb_data  input  32  LSU load data
lsu_wb_rdy  output  1  LSU request granted this cycle
div_wb_vld  input  1  divider write-back valid (held until div_wb_rdy)
div_wb_dst  input  5  divider destination GPR index
div_wb_data  input  32  divider result
div_wb_rdy  output  1  DIV request granted this cycle
arb_alu_stall_req  output  1  request to IDU issue: block ALU issue next cycle
wb_vld  output  1  registered write-back valid
wb_dst  output  5  registered destination index
wb_data  output  32  registered write data
wb_flsu_vld  output  1  registered: the current write-back came from the LSU
wb_reg_write_en  output  32  registered one-hot write enable; bit 0 is always 0

Behaviour:
- Reset (cpurst=1, asynchronous) clears the following to 0: wb_vld, wb_dst, wb_data, wb_flsu_vld, wb_reg_write_en, arb_alu_stall_req, the starvation counter, and the round-robin pointer rr_last. rr_last=0 means the LSU won last, so DIV has priority next.
- Grant is combinational and uses fixed priority:
  1) alu_wb_vld=1 -> ALU is granted; lsu_wb_rdy=div_wb_rdy=0.
  2) ALU idle with exactly one of LSU/DIV valid -> that requester is granted.
  3) ALU idle with both valid -> the requester not recorded in rr_last is granted; rr_last then updates to the winner.
- lsu_wb_rdy/div_wb_rdy are asserted only in the grant cycle. A transfer completes when vld&rdy on the posedge.
- Requesters hold vld, dst and data stable until rdy. The arbiter does not buffer requests.
- Write-back stage has 1-cycle latency: the winner's dst/data is registered at the posedge following the grant.
  - wb_vld=1 for exactly one cycle per grant.
  - wb_flsu_vld=1 iff the LSU was the winner.
  - wb_reg_write_en = one-hot(dst) if dst!=0; all-zero if dst==0. wb_vld still asserts when dst==0.
- With no grant: wb_vld, wb_flsu_vld and wb_reg_write_en go to 0; wb_dst and wb_data hold their previous values.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle (lsu_wb_vld|div_wb_vld) is 1 and no LSU/DIV grant occurs.
  - Clears on any LSU/DIV grant, and clears when neither LSU nor DIV is valid.
- arb_alu_stall_req is a register. It is set the cycle after the counter reaches STARVE_MAX, and cleared the cycle after an LSU/DIV grant or when both are idle.
- ALU always wins, even while arb_alu_stall_req=1. Issue logic is responsible for honouring the stall; the arbiter does not drop ALU write-backs.
- Simultaneous events:
  - If an LSU/DIV grant occurs in the same cycle the counter would reach STARVE_MAX, the counter clears and the stall is not set.
  - A new request presented in the cycle right after a handshake is granted normally; back-to-back grants to the same requester are allowed if the other requester is idle.
- Reset mid-handshake: pending requests are not remembered. Requesters re-present after reset; the arbiter treats them as new.

Test Plan:
- Reset, then LSU vld, dst=5, data=0x1234 with ALU idle -> lsu_wb_rdy=1 the same cycle. Next cycle: wb_vld=1, wb_dst=5, wb_data=0x1234, wb_flsu_vld=1, wb_reg_write_en=0x0000_0020.
- ALU vld dst=3 and LSU vld dst=7 in the same cycle -> ALU granted, lsu_wb_rdy=0. LSU holds; the next cycle with ALU idle grants LSU. Write-backs appear in order dst 3 then dst 7, with wb_flsu_vld 0 then 1.
- LSU and DIV both valid from reset with ALU idle -> DIV granted first (rr_last=0), then LSU, then DIV, alternating on each handshake.
- ALU vld every cycle while DIV is held valid, STARVE_MAX=4 -> arb_alu_stall_req rises in cycle 5 after DIV vld. After ALU drops vld, DIV is granted and stall_req falls the following cycle.
- DIV write with dst=0, data=0xFFFF_FFFF -> wb_vld=1, wb_flsu_vld=0, wb_reg_write_en=0.
- Assert cpurst asynchronously while DIV is pending and stall_req=1 -> all outputs read 0 immediately. After release, rr_last=0 and the counter restarts from 0.
